pipelined_mux_tree: RTL and testbench



---
 rtl/mux_tree_pkg.sv | 34 +++
 rtl/pipelined_mux_tree_if.sv | 44 ++++
 rtl/mux_tree_stage.sv | 107 ++++++++++
 rtl/pipelined_mux_tree.sv | 127 ++++++++++++
 tb/tb_pipelined_mux_tree.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_tree_pkg.sv
// -----------------------------------------------------------------------------
// mux_tree_pkg
// Shared helpers for the pipelined mux tree. They turn the user parameters
// (number of sources, tree levels per register stage) into the derived sizes
// that the interface, the top and every stage slice must agree on.
//   selWidth      : select width, $clog2 of the source count
//   paddedInputs  : source count rounded up to the next power of two
//   treeLatency   : number of register stages, ceil(levels / stageLevels)
//   levelsInStage : how many 2:1 levels a given stage resolves
// There are no ports; this file only holds constant functions.
// -----------------------------------------------------------------------------
package mux_tree_pkg;

    // A single source still needs one select bit so that the vectors are legal.
    function automatic int selWidth(input int inputs);
        return (inputs < 2) ? 1 : $clog2(inputs);
    endfunction

    function automatic int paddedInputs(input int inputs);
        return 1 << selWidth(inputs);
    endfunction

    function automatic int treeLatency(input int inputs, input int stageLevels);
        return (selWidth(inputs) + stageLevels - 1) / stageLevels;
    endfunction

    // The last stage may resolve fewer levels than the others.
    function automatic int levelsInStage(input int inputs, input int stageLevels, input int stage);
        int remaining;
        remaining = selWidth(inputs) - stage * stageLevels;
        return (remaining < stageLevels) ? remaining : stageLevels;
    endfunction

endpackage

// File: rtl/pipelined_mux_tree_if.sv
// -----------------------------------------------------------------------------
// pipelined_mux_tree_if
// Bundles the streaming handshake and data signals of the pipelined mux tree.
//   in_data   : INPUTS*WIDTH source bus, source i at [i*WIDTH +: WIDTH]
//   sel       : requested source index (ignored while scan_en is high)
//   scan_en   : let the internal round-robin counter pick the source
//   in_valid  : producer offers a beat
//   in_ready  : mux tree accepts the beat this cycle
//   out_data  : selected word
//   out_sel   : select value that produced out_data
//   out_oor   : select pointed past the last real source, out_data is zero
//   out_valid : output beat present
//   out_ready : consumer takes the output beat this cycle
// Modports: master = producer/consumer side, slave = the mux tree.
// -----------------------------------------------------------------------------
interface pipelined_mux_tree_if #(
    parameter int INPUTS = 6,
    parameter int WIDTH  = 8
);
    import mux_tree_pkg::*;

    localparam int SELW = selWidth(INPUTS);

    logic [INPUTS*WIDTH-1:0] in_data;
    logic [SELW-1:0]         sel;
    logic                    scan_en;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SELW-1:0]         out_sel;
    logic                    out_oor;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, sel, scan_en, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_oor, out_valid
    );

    modport slave (
        input  in_data, sel, scan_en, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_oor, out_valid
    );
endinterface

// File: rtl/mux_tree_stage.sv
// -----------------------------------------------------------------------------
// mux_tree_stage
// One pipeline slice of the mux tree: LEVELS_HERE combinational 2:1 levels
// followed by a payload register with a valid bit and a pass-through ready.
// Tree level l (global FIRST_LEVEL + l) is steered by that bit of the full
// select, which travels alongside the data as out_sel.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   inValid_i   : upstream beat present
//   inReady_o   : this slice can load this cycle
//   inData_i    : IN_WAYS words still to be reduced
//   inSel_i     : full select of the beat
//   inOor_i     : beat selected a padding source
//   outValid_o  : this slice holds a beat
//   adv_i       : downstream can take the held beat this cycle
//   outData_o   : IN_WAYS >> LEVELS_HERE words after this slice
//   outSel_o    : registered select
//   outOor_o    : registered out-of-range flag
// -----------------------------------------------------------------------------
module mux_tree_stage #(
    parameter int IN_WAYS     = 8,
    parameter int LEVELS_HERE = 1,
    parameter int WIDTH       = 8,
    parameter int SELW        = 3,
    parameter int FIRST_LEVEL = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    inValid_i,
    output logic                                    inReady_o,
    input  logic [IN_WAYS*WIDTH-1:0]                inData_i,
    input  logic [SELW-1:0]                         inSel_i,
    input  logic                                    inOor_i,
    output logic                                    outValid_o,
    input  logic                                    adv_i,
    output logic [(IN_WAYS>>LEVELS_HERE)*WIDTH-1:0] outData_o,
    output logic [SELW-1:0]                         outSel_o,
    output logic                                    outOor_o
);
    localparam int OUT_WAYS = IN_WAYS >> LEVELS_HERE;

    typedef struct packed {
        logic [OUT_WAYS*WIDTH-1:0] data;
        logic [SELW-1:0]           outSel;
        logic                      oor;
    } payload_t;

    logic [WIDTH-1:0] levelData [LEVELS_HERE+1][IN_WAYS];
    payload_t         payload_d;
    payload_t         payload_q;
    logic             valid_q;
    logic             load;

    // Reduce the incoming words level by level. Level l pairs neighbours
    // (2w, 2w+1) and keeps the odd one when its select bit is set. Entries a
    // level no longer uses are parked at zero.
    always_comb begin
        for (int l = 0; l <= LEVELS_HERE; l++) begin
            for (int w = 0; w < IN_WAYS; w++) begin
                levelData[l][w] = '0;
            end
        end
        for (int w = 0; w < IN_WAYS; w++) begin
            levelData[0][w] = inData_i[w*WIDTH +: WIDTH];
        end
        for (int l = 0; l < LEVELS_HERE; l++) begin
            for (int w = 0; w < IN_WAYS / 2; w++) begin
                if (w < (IN_WAYS >> (l + 1))) begin
                    levelData[l+1][w] = inSel_i[FIRST_LEVEL+l] ? levelData[l][2*w+1]
                                                               : levelData[l][2*w];
                end
            end
        end
        payload_d.data = '0;
        for (int w = 0; w < OUT_WAYS; w++) begin
            payload_d.data[w*WIDTH +: WIDTH] = levelData[LEVELS_HERE][w];
        end
        payload_d.outSel = inSel_i;
        payload_d.oor    = inOor_i;
    end

    // The slice may load whenever it is empty or its beat leaves this cycle;
    // that same condition is the ready seen upstream, so the chain has no
    // bubbles at full rate.
    assign load      = !valid_q || adv_i;
    assign inReady_o = load;

    // Payload register. When loading an empty slot the old payload is kept so
    // outputs do not wiggle while nothing valid is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else if (load) begin
            valid_q <= inValid_i;
            if (inValid_i) begin
                payload_q <= payload_d;
            end
        end
    end

    assign outValid_o = valid_q;
    assign outData_o  = payload_q.data;
    assign outSel_o   = payload_q.outSel;
    assign outOor_o   = payload_q.oor;

endmodule

// File: rtl/pipelined_mux_tree.sv
// -----------------------------------------------------------------------------
// pipelined_mux_tree
// Pipelined N:1 word selector. The source bus is zero-padded to a power of
// two and reduced by a binary 2:1 tree, with a register slice after every
// STAGE_LEVELS levels. A valid/ready handshake gives back-pressure and an
// optional scan mode sweeps the select round-robin over the real sources.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : pipelined_mux_tree_if slave modport (in_data, sel, scan_en,
//            in_valid/in_ready, out_data, out_sel, out_oor,
//            out_valid/out_ready)
// -----------------------------------------------------------------------------
module pipelined_mux_tree
    import mux_tree_pkg::*;
#(
    parameter int INPUTS       = 6,
    parameter int WIDTH        = 8,
    parameter int STAGE_LEVELS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_mux_tree_if.slave  bus
);
    localparam int SELW = selWidth(INPUTS);
    localparam int PAD  = paddedInputs(INPUTS);
    localparam int LAT  = treeLatency(INPUTS, STAGE_LEVELS);

    localparam logic [SELW:0]   INPUTS_W = (SELW+1)'(INPUTS);
    localparam logic [SELW-1:0] LAST_IDX = SELW'(INPUTS - 1);

    logic [PAD*WIDTH-1:0] paddedData;
    logic [SELW-1:0]      scanCnt_q;
    logic [SELW-1:0]      scanCnt_d;
    logic [SELW-1:0]      effSel;
    logic                 effOor;
    logic                 accept;

    logic                 validChain [LAT+1];
    logic                 readyChain [LAT+1];
    logic [SELW-1:0]      selChain   [LAT+1];
    logic                 oorChain   [LAT+1];

    // Padding sources read as zero, which is what makes an out-of-range
    // select produce zero data without a separate data mask.
    always_comb begin
        paddedData                     = '0;
        paddedData[INPUTS*WIDTH-1:0]   = bus.in_data;
    end

    // The effective select is resolved here so scan_en changes take effect
    // on this cycle's acceptance, and the flag rides with the beat.
    always_comb begin
        effSel = bus.scan_en ? scanCnt_q : bus.sel;
        effOor = ({1'b0, effSel} >= INPUTS_W);
    end

    assign accept = bus.in_valid && readyChain[0];

    // Sweep counter: advances only on accepted beats in scan mode and wraps
    // at the last real source so it never lands on padding.
    always_comb begin
        scanCnt_d = scanCnt_q;
        if (accept && bus.scan_en) begin
            scanCnt_d = (scanCnt_q == LAST_IDX) ? '0 : scanCnt_q + 1'b1;
        end
    end

    // Sweep counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scanCnt_q <= '0;
        end else begin
            scanCnt_q <= scanCnt_d;
        end
    end

    assign validChain[0]   = bus.in_valid;
    assign selChain[0]     = effSel;
    assign oorChain[0]     = effOor;
    assign readyChain[LAT] = bus.out_ready;
    assign bus.in_ready    = readyChain[0];

    // Each slice k sees the words still left after k*STAGE_LEVELS levels and
    // hands its reduced set to slice k+1.
    for (genvar k = 0; k < LAT; k++) begin : g_stage
        localparam int IN_W  = PAD >> (k * STAGE_LEVELS);
        localparam int LV    = levelsInStage(INPUTS, STAGE_LEVELS, k);
        localparam int OUT_W = IN_W >> LV;

        logic [IN_W*WIDTH-1:0]  stageIn;
        logic [OUT_W*WIDTH-1:0] stageOut;

        if (k == 0) begin : g_first
            assign stageIn = paddedData;
        end else begin : g_next
            assign stageIn = g_stage[k-1].stageOut;
        end

        mux_tree_stage #(
            .IN_WAYS     (IN_W),
            .LEVELS_HERE (LV),
            .WIDTH       (WIDTH),
            .SELW        (SELW),
            .FIRST_LEVEL (k * STAGE_LEVELS)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .inValid_i  (validChain[k]),
            .inReady_o  (readyChain[k]),
            .inData_i   (stageIn),
            .inSel_i    (selChain[k]),
            .inOor_i    (oorChain[k]),
            .outValid_o (validChain[k+1]),
            .adv_i      (readyChain[k+1]),
            .outData_o  (stageOut),
            .outSel_o   (selChain[k+1]),
            .outOor_o   (oorChain[k+1])
        );
    end

    assign bus.out_data  = g_stage[LAT-1].stageOut;
    assign bus.out_valid = validChain[LAT];
    assign bus.out_sel   = selChain[LAT];
    assign bus.out_oor   = oorChain[LAT];

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// -----------------------------------------------------------------------------
// tb_pipelined_mux_tree
// Two instances share clock and reset: dutA (STAGE_LEVELS=1, three register
// stages) carries the streaming, back-pressure, scan and reset sequences;
// dutB (STAGE_LEVELS=4, one register stage) covers the single-stage case.
// Expected beats come from a constant vector table and are queued when the
// DUT accepts a beat, then compared when the DUT emits one.
// -----------------------------------------------------------------------------
module tb_pipelined_mux_tree;

    localparam int LAT_A = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipelined_mux_tree_if #(.INPUTS(6), .WIDTH(8)) busA ();
    pipelined_mux_tree_if #(.INPUTS(6), .WIDTH(8)) busB ();

    pipelined_mux_tree #(.INPUTS(6), .WIDTH(8), .STAGE_LEVELS(1)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA)
    );

    pipelined_mux_tree #(.INPUTS(6), .WIDTH(8), .STAGE_LEVELS(4)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB)
    );

    typedef struct {
        logic [2:0] sel;
        logic       scanEn;
        logic [7:0] expData;
        logic [2:0] expSel;
        logic       expOor;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] sel;
        logic       oor;
        int         cycle;
        bit         checkLat;
    } exp_t;

    vec_t vecs [20];
    vec_t stallVecs [5];
    exp_t sbQ [$];
    exp_t offerExp;
    int   checks   = 0;
    int   errors   = 0;
    int   cycle    = 0;
    int   popCount = 0;
    bit   accepted;

    // One comparison: counts it, and reports actual vs required on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Evaluates the handshakes that the coming rising edge will perform,
    // scoreboards them, then advances to the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        if (busA.out_valid && busA.out_ready) begin
            popCount++;
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedOutput: got beat data=0x%0h sel=%0d, required no beat", busA.out_data, busA.out_sel);
            end else begin
                e = sbQ.pop_front();
                checkOutput("outData", busA.out_data, e.data);
                checkOutput("outSel", busA.out_sel, e.sel);
                checkOutput("outOor", busA.out_oor, e.oor);
                if (e.checkLat) begin
                    checkOutput("latency", cycle - e.cycle, LAT_A);
                end
            end
        end
        if (busA.in_valid && busA.in_ready) begin
            e       = offerExp;
            e.cycle = cycle;
            sbQ.push_back(e);
            accepted = 1'b1;
        end
        @(posedge clk);
        cycle++;
        @(negedge clk);
    endtask

    // Offers one beat to dutA and waits (bounded) until it is accepted.
    task automatic applyStimulus(input vec_t v, input bit checkLat);
        busA.sel      = v.sel;
        busA.scan_en  = v.scanEn;
        busA.in_valid = 1'b1;
        offerExp      = '{v.expData, v.expSel, v.expOor, 0, checkLat};
        accepted      = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            tick();
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout: beat sel=%0d not accepted, required acceptance within 20 cycles", v.sel);
        end
        busA.in_valid = 1'b0;
    endtask

    // Lets every queued beat leave dutA, bounded.
    task automatic drain();
        busA.in_valid = 1'b0;
        for (int i = 0; i < 30 && sbQ.size() > 0; i++) begin
            tick();
        end
        checkOutput("drainEmpty", sbQ.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int pops0;

        // Constant vector table: direct selects, padding selects, scan sweep,
        // manual override inside the sweep, then sweep resume.
        for (int i = 0; i < 6; i++) begin
            vecs[i] = '{3'(i), 1'b0, 8'((i + 1) * 8'h11), 3'(i), 1'b0};
        end
        vecs[6] = '{3'd6, 1'b0, 8'h00, 3'd6, 1'b1};
        vecs[7] = '{3'd7, 1'b0, 8'h00, 3'd7, 1'b1};
        for (int i = 0; i < 8; i++) begin
            vecs[8+i] = '{3'd7, 1'b1, 8'(((i % 6) + 1) * 8'h11), 3'(i % 6), 1'b0};
        end
        vecs[16] = '{3'd3, 1'b0, 8'h44, 3'd3, 1'b0};
        vecs[17] = '{3'd3, 1'b0, 8'h44, 3'd3, 1'b0};
        vecs[18] = '{3'd7, 1'b1, 8'h33, 3'd2, 1'b0};
        vecs[19] = '{3'd7, 1'b1, 8'h44, 3'd3, 1'b0};
        for (int i = 0; i < 5; i++) begin
            stallVecs[i] = '{3'(i + 1), 1'b0, 8'((i + 2) * 8'h11), 3'(i + 1), 1'b0};
        end

        rst_n         = 1'b0;
        busA.in_data  = 48'h66_55_44_33_22_11;
        busA.sel      = '0;
        busA.scan_en  = 1'b0;
        busA.in_valid = 1'b0;
        busA.out_ready = 1'b1;
        busB.in_data  = 48'h66_55_44_33_22_11;
        busB.sel      = '0;
        busB.scan_en  = 1'b0;
        busB.in_valid = 1'b0;
        busB.out_ready = 1'b1;

        @(negedge clk);
        @(negedge clk);
        checkOutput("rstOutValid", busA.out_valid, 0);
        checkOutput("rstOutData", busA.out_data, 0);
        checkOutput("rstOutSel", busA.out_sel, 0);
        checkOutput("rstOutOor", busA.out_oor, 0);
        checkOutput("rstBOutValid", busB.out_valid, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("rstInReady", busA.in_ready, 1);
        checkOutput("rstBInReady", busB.in_ready, 1);
        @(negedge clk);

        // Back-to-back table stream, consumer always ready.
        $display("[TB] table stream");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i], 1'b1);
        end
        drain();

        // Back-pressure: three beats fill the pipe, the fourth is refused.
        $display("[TB] back-pressure");
        pops0 = popCount;
        busA.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(stallVecs[i], 1'b0);
        end
        busA.sel      = stallVecs[3].sel;
        busA.scan_en  = 1'b0;
        busA.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("stallInReady", busA.in_ready, 0);
            checkOutput("stallOutValid", busA.out_valid, 1);
            checkOutput("stallOutData", busA.out_data, 8'h22);
            checkOutput("stallOutSel", busA.out_sel, 1);
            @(posedge clk);
            cycle++;
            @(negedge clk);
        end
        busA.out_ready = 1'b1;
        offerExp = '{stallVecs[3].expData, stallVecs[3].expSel, stallVecs[3].expOor, 0, 1'b0};
        accepted = 1'b0;
        tick();
        checkOutput("releaseSameCycle", accepted, 1);
        if (!accepted) begin
            applyStimulus(stallVecs[3], 1'b0);
        end
        applyStimulus(stallVecs[4], 1'b0);
        drain();
        checkOutput("stallPopCount", popCount - pops0, 5);

        // Reset with a full pipe: everything in flight is dropped and the
        // sweep counter restarts at zero.
        $display("[TB] reset mid-stream");
        busA.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[8+i], 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstOutValid", busA.out_valid, 0);
        checkOutput("midRstOutData", busA.out_data, 0);
        checkOutput("midRstOutSel", busA.out_sel, 0);
        checkOutput("midRstInReady", busA.in_ready, 1);
        sbQ.delete();
        busA.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        busA.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        applyStimulus('{3'd7, 1'b1, 8'h11, 3'd0, 1'b0}, 1'b1);
        drain();

        // Single register stage: the result follows one edge after acceptance.
        $display("[TB] single-stage instance");
        busB.sel      = 3'd4;
        busB.in_valid = 1'b1;
        #1;
        checkOutput("bInReady", busB.in_ready, 1);
        @(negedge clk);
        busB.sel = 3'd6;
        #1;
        checkOutput("bOutValid", busB.out_valid, 1);
        checkOutput("bOutData", busB.out_data, 8'h55);
        checkOutput("bOutSel", busB.out_sel, 4);
        checkOutput("bOutOor", busB.out_oor, 0);
        @(negedge clk);
        busB.in_valid = 1'b0;
        #1;
        checkOutput("bOorValid", busB.out_valid, 1);
        checkOutput("bOorData", busB.out_data, 8'h00);
        checkOutput("bOorSel", busB.out_sel, 6);
        checkOutput("bOorFlag", busB.out_oor, 1);
        @(negedge clk);
        #1;
        checkOutput("bIdleValid", busB.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
